// File: rtl/definitions.sv
// Shared types and defaults for the fetch sequencer.
package definitions;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_RUN  = 2'd1,
        F_DONE = 2'd2
    } fetch_st;

    localparam int PC_W_DEF  = 10;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    // Next count: clear has priority, increment stops at all-ones.
    always_comb begin
        q_d = q_q;
        if (clear)
            q_d = '0;
        else if (inc && !(&q_q))
            q_d = q_q + W'(1);
    end

    // Count register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch sequencer: IDLE-RUN-DONE handshake, next-PC priority mux,
// and per-run cycle / PC-advance counters.
module fetch_unit
    import definitions::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             Halt,
    input  logic             branch_en,
    input  logic             cond,
    input  logic             jump_en,
    input  logic [8:0]       Target,
    input  logic             program_done,
    output logic [PC_W-1:0]  PC,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] adv_cnt
);

    fetch_st         state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            cnt_clr;
    logic            cyc_inc;
    logic            adv_inc;

    // Next state, next PC and counter strobes. The PC mux order is
    // done > jump > taken branch > sequential > hold.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_clr = 1'b0;
        cyc_inc = 1'b0;
        adv_inc = 1'b0;
        unique case (state_q)
            F_IDLE, F_DONE: begin
                if (start) begin
                    state_d = F_RUN;
                    pc_d    = start_addr;
                    cnt_clr = 1'b1;
                end
            end
            F_RUN: begin
                cyc_inc = 1'b1;
                if (program_done) begin
                    state_d = F_DONE;
                end else if (jump_en) begin
                    pc_d    = PC_W'(Target);
                    adv_inc = 1'b1;
                end else if (branch_en && cond) begin
                    // Offset is two's complement; PC arithmetic wraps.
                    pc_d    = pc_q + PC_W'($signed(Target));
                    adv_inc = 1'b1;
                end else if (!Halt) begin
                    pc_d    = pc_q + PC_W'(1);
                    adv_inc = 1'b1;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // State and PC registers; reset beats a simultaneous start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= F_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clear (cnt_clr),
        .inc   (cyc_inc),
        .q     (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_adv_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clear (cnt_clr),
        .inc   (adv_inc),
        .q     (adv_cnt)
    );

    assign PC   = pc_q;
    assign busy = (state_q == F_RUN);
    assign done = (state_q == F_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus a saturation check on a
// narrow-counter instance.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST, start, Halt, branch_en, cond, jump_en, program_done;
    logic [9:0]  start_addr;
    logic [8:0]  Target;
    logic [9:0]  PC;
    logic        busy, done;
    logic [15:0] cycle_cnt, adv_cnt;

    // narrow-counter instance for saturation
    logic        s_rst, s_start, s_halt;
    logic [9:0]  s_pc;
    logic        s_busy, s_done;
    logic [3:0]  s_cyc, s_adv;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.PC_W(10), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .start_addr(start_addr),
        .Halt(Halt), .branch_en(branch_en), .cond(cond), .jump_en(jump_en),
        .Target(Target), .program_done(program_done), .PC(PC), .busy(busy),
        .done(done), .cycle_cnt(cycle_cnt), .adv_cnt(adv_cnt)
    );

    fetch_unit #(.PC_W(10), .CNT_W(4)) dut_s (
        .CLK(CLK), .RST(s_rst), .start(s_start), .start_addr(10'h000),
        .Halt(s_halt), .branch_en(1'b0), .cond(1'b0), .jump_en(1'b0),
        .Target(9'h000), .program_done(1'b0), .PC(s_pc), .busy(s_busy),
        .done(s_done), .cycle_cnt(s_cyc), .adv_cnt(s_adv)
    );

    typedef struct {
        logic       rst, st;
        logic [9:0] addr;
        logic       halt, br, cnd, jmp;
        logic [8:0] tgt;
        logic       pd;
        logic [9:0] e_pc;
        logic       e_busy, e_done;
        int         e_cyc, e_adv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic st, logic [9:0] addr,
                                logic halt, logic br, logic cnd, logic jmp,
                                logic [8:0] tgt, logic pd, logic [9:0] e_pc,
                                logic e_busy, logic e_done, int e_cyc, int e_adv);
        vec_t v;
        v.rst = rst; v.st = st; v.addr = addr; v.halt = halt; v.br = br;
        v.cnd = cnd; v.jmp = jmp; v.tgt = tgt; v.pd = pd; v.e_pc = e_pc;
        v.e_busy = e_busy; v.e_done = e_done; v.e_cyc = e_cyc; v.e_adv = e_adv;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; start_addr = '0; Halt = 1'b1; branch_en = 1'b0;
        cond = 1'b0; jump_en = 1'b0; Target = '0; program_done = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_halt = 1'b1;

        //          rst st addr    hlt br cnd jmp tgt     pd  pc      bsy dn cyc adv
        vecs.push_back(mk(1, 1, 10'h155, 0, 1, 1, 1, 9'h0AA, 1, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 10'h155, 0, 0, 0, 1, 9'h0AA, 0, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 10'h020, 1, 0, 0, 0, 9'h000, 0, 10'h020, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 9'h000, 0, 10'h021, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 9'h000, 0, 10'h022, 1, 0, 2, 2));
        vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 9'h000, 0, 10'h023, 1, 0, 3, 3));
        vecs.push_back(mk(0, 0, 10'h000, 1, 0, 0, 0, 9'h000, 0, 10'h023, 1, 0, 4, 3));
        vecs.push_back(mk(0, 0, 10'h000, 1, 0, 0, 0, 9'h000, 0, 10'h023, 1, 0, 5, 3));
        vecs.push_back(mk(0, 0, 10'h000, 1, 0, 0, 1, 9'h030, 0, 10'h030, 1, 0, 6, 4));
        vecs.push_back(mk(0, 0, 10'h000, 1, 1, 1, 0, 9'h1FC, 0, 10'h02C, 1, 0, 7, 5));
        vecs.push_back(mk(0, 0, 10'h000, 1, 0, 0, 1, 9'h030, 0, 10'h030, 1, 0, 8, 6));
        vecs.push_back(mk(0, 0, 10'h000, 0, 1, 0, 0, 9'h1FC, 0, 10'h031, 1, 0, 9, 7));
        vecs.push_back(mk(0, 0, 10'h000, 1, 1, 0, 0, 9'h1FC, 0, 10'h031, 1, 0, 10, 7));
        vecs.push_back(mk(0, 0, 10'h000, 0, 1, 1, 1, 9'h105, 0, 10'h105, 1, 0, 11, 8));
        vecs.push_back(mk(0, 0, 10'h000, 1, 1, 1, 0, 9'h0FF, 0, 10'h204, 1, 0, 12, 9));
        vecs.push_back(mk(0, 0, 10'h000, 0, 1, 1, 1, 9'h010, 1, 10'h204, 0, 1, 13, 9));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 10'h000, 0, 1, 1, 1, 9'h010, 1, 10'h204, 0, 1, 13, 9));
        vecs.push_back(mk(0, 1, 10'h3FF, 1, 0, 0, 0, 9'h000, 0, 10'h3FF, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 9'h000, 0, 10'h000, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 10'h000, 1, 1, 1, 0, 9'h1FE, 0, 10'h3FE, 1, 0, 2, 2));
        vecs.push_back(mk(0, 1, 10'h080, 1, 0, 0, 0, 9'h000, 0, 10'h3FE, 1, 0, 3, 2));
        vecs.push_back(mk(0, 0, 10'h000, 1, 0, 0, 0, 9'h000, 1, 10'h3FE, 0, 1, 4, 2));
        vecs.push_back(mk(0, 1, 10'h080, 1, 0, 0, 0, 9'h000, 0, 10'h080, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 0, 0, 0, 0, 9'h000, 0, 10'h081, 1, 0, 1, 1));
        vecs.push_back(mk(1, 0, 10'h000, 0, 0, 0, 0, 9'h000, 0, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 10'h000, 0, 1, 1, 1, 9'h0F0, 1, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 10'h040, 0, 0, 0, 0, 9'h000, 0, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 10'h040, 1, 0, 0, 0, 9'h000, 0, 10'h040, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst; start = vecs[i].st; start_addr = vecs[i].addr;
            Halt = vecs[i].halt; branch_en = vecs[i].br; cond = vecs[i].cnd;
            jump_en = vecs[i].jmp; Target = vecs[i].tgt; program_done = vecs[i].pd;
            @(posedge CLK); #1;
            chk("pc",   i, 32'(PC),        32'(vecs[i].e_pc));
            chk("busy", i, 32'(busy),      32'(vecs[i].e_busy));
            chk("done", i, 32'(done),      32'(vecs[i].e_done));
            chk("cyc",  i, 32'(cycle_cnt), 32'(vecs[i].e_cyc));
            chk("adv",  i, 32'(adv_cnt),   32'(vecs[i].e_adv));
        end

        // Saturation: 4-bit counters must stick at 15 while PC keeps going.
        @(negedge CLK); s_rst = 1'b0; s_start = 1'b1;
        @(negedge CLK); s_start = 1'b0; s_halt = 1'b0;
        repeat (20) @(negedge CLK);
        chk("sat_pc",  100, 32'(s_pc),   32'd20);
        chk("sat_cyc", 100, 32'(s_cyc),  32'd15);
        chk("sat_adv", 100, 32'(s_adv),  32'd15);
        chk("sat_bsy", 100, 32'(s_busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
